// File: rtl/filt_pkg.sv
// Shared types and clamp helpers for the time-multiplexed debounce controller.
package filt_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    SCAN = 2'd2
  } state_e;

  function automatic int ch_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int unsigned eff_thresh(input int unsigned t);
    return (t == 32'd0) ? 32'd1 : t;
  endfunction

  // A scan takes N_CH cycles, so the sample period must leave room for it plus the WAIT step.
  function automatic int unsigned eff_div(input int unsigned d, input int unsigned n_ch);
    return (d < (n_ch + 32'd1)) ? (n_ch + 32'd1) : d;
  endfunction

endpackage

// File: rtl/filt_tick_gen.sv
// Sample-period prescaler: counts while enabled and pulses tick_o for one cycle when the count hits div_i.
module filt_tick_gen #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic             clr_i,
  input  logic [DIV_W-1:0] div_i,
  output logic             tick_o
);

  logic [DIV_W-1:0] cnt_q, cnt_d;

  always_comb begin
    tick_o = en_i && (cnt_q == div_i);
    cnt_d  = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (tick_o) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + {{(DIV_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/filt_scan_ctrl.sv
// Debounce controller: one shared run-length filter walks all channels after each sample tick
// and reports every level flip through a single-entry valid/ready event slot.
module filt_scan_ctrl
  import filt_pkg::*;
#(
  parameter int N_CH  = 8,
  parameter int CNT_W = 4,
  parameter int DIV_W = 16,
  localparam int CH_W = ch_w(N_CH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [DIV_W-1:0] div,
  input  logic [CNT_W-1:0] thresh,
  input  logic [N_CH-1:0]  raw,
  output logic [N_CH-1:0]  filt,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [CH_W-1:0]  evt_ch,
  output logic             evt_level,
  output logic             busy,
  output logic             ovf,
  input  logic             ovf_clr
);

  state_e            state_q, state_d;
  logic [CH_W-1:0]   idx_q, idx_d;
  logic [N_CH-1:0]   snap_q, snap_d;
  logic [N_CH-1:0]   filt_q, filt_d;
  logic [CNT_W-1:0]  cnt_q [N_CH];
  logic [CNT_W-1:0]  cnt_d [N_CH];
  logic              evt_valid_q, evt_valid_d;
  logic [CH_W-1:0]   evt_ch_q, evt_ch_d;
  logic              evt_level_q, evt_level_d;
  logic              ovf_q, ovf_d;
  logic              tick_s;
  logic              slot_free_s;
  int unsigned       run_inc_s;
  int unsigned       thr_s;

  filt_tick_gen #(.DIV_W(DIV_W)) u_tick (
    .clk    (clk),
    .rst_n  (rst_n),
    .en_i   (state_q != IDLE),
    .clr_i  (state_q == IDLE),
    .div_i  (DIV_W'(eff_div(32'(div), unsigned'(N_CH)))),
    .tick_o (tick_s)
  );

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    snap_d      = snap_q;
    filt_d      = filt_q;
    cnt_d       = cnt_q;
    evt_valid_d = evt_valid_q;
    evt_ch_d    = evt_ch_q;
    evt_level_d = evt_level_q;
    ovf_d       = ovf_q;
    slot_free_s = !evt_valid_q || evt_ready;
    run_inc_s   = 32'(cnt_q[idx_q]) + 32'd1;
    thr_s       = eff_thresh(32'(thresh));

    if (evt_valid_q && evt_ready) begin
      evt_valid_d = 1'b0;
    end else begin
      evt_valid_d = evt_valid_q;
    end
    // Clear first so a same-cycle drop below still sets the flag.
    if (ovf_clr) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end

    if (!en) begin
      state_d = IDLE;
      for (int i = 0; i < N_CH; i++) cnt_d[i] = '0;
    end else begin
      case (state_q)
        IDLE: state_d = WAIT;
        WAIT: begin
          if (tick_s) begin
            state_d = SCAN;
            snap_d  = raw;
            idx_d   = '0;
          end else begin
            state_d = WAIT;
          end
        end
        SCAN: begin
          if (snap_q[idx_q] == filt_q[idx_q]) begin
            cnt_d[idx_q] = '0;
          end else if (run_inc_s >= thr_s) begin
            filt_d[idx_q] = ~filt_q[idx_q];
            cnt_d[idx_q]  = '0;
            if (slot_free_s) begin
              evt_valid_d = 1'b1;
              evt_ch_d    = idx_q;
              evt_level_d = ~filt_q[idx_q];
            end else begin
              ovf_d = 1'b1;
            end
          end else if (cnt_q[idx_q] != {CNT_W{1'b1}}) begin
            cnt_d[idx_q] = cnt_q[idx_q] + {{(CNT_W-1){1'b0}}, 1'b1};
          end else begin
            cnt_d[idx_q] = cnt_q[idx_q];
          end
          if (idx_q == CH_W'(N_CH - 1)) begin
            state_d = WAIT;
          end else begin
            idx_d = idx_q + {{(CH_W-1){1'b0}}, 1'b1};
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      snap_q      <= '0;
      filt_q      <= '0;
      evt_valid_q <= 1'b0;
      evt_ch_q    <= '0;
      evt_level_q <= 1'b0;
      ovf_q       <= 1'b0;
      for (int i = 0; i < N_CH; i++) cnt_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      snap_q      <= snap_d;
      filt_q      <= filt_d;
      evt_valid_q <= evt_valid_d;
      evt_ch_q    <= evt_ch_d;
      evt_level_q <= evt_level_d;
      ovf_q       <= ovf_d;
      for (int i = 0; i < N_CH; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign filt      = filt_q;
  assign evt_valid = evt_valid_q;
  assign evt_ch    = evt_ch_q;
  assign evt_level = evt_level_q;
  assign ovf       = ovf_q;
  assign busy      = (state_q == SCAN);

endmodule
